// File: rtl/legv8_ctrl_pkg.sv
// Shared types, opcode/condition constants and decode helpers for the LEGv8
// multicycle controller.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_LSL    = 3'd3,
    ALU_LSR    = 3'd4
  } alu_op_t;

  typedef enum logic [3:0] {
    I_ADDS, I_SUBS, I_LSL, I_LSR, I_LDUR, I_STUR,
    I_ADDI, I_CBZ, I_BCOND, I_B, I_ILLEGAL
  } iclass_t;

  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LSL   = 11'b11010011011;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [5:0]  OP_B     = 6'b000101;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Longest opcode wins: 11-bit, then 10, 8 and 6-bit fields.
  function automatic iclass_t decode_op(input logic [31:0] i);
    iclass_t c;
    c = I_ILLEGAL;
    if      (i[31:21] == OP_ADDS)  c = I_ADDS;
    else if (i[31:21] == OP_SUBS)  c = I_SUBS;
    else if (i[31:21] == OP_LSL)   c = I_LSL;
    else if (i[31:21] == OP_LSR)   c = I_LSR;
    else if (i[31:21] == OP_LDUR)  c = I_LDUR;
    else if (i[31:21] == OP_STUR)  c = I_STUR;
    else if (i[31:22] == OP_ADDI)  c = I_ADDI;
    else if (i[31:24] == OP_CBZ)   c = I_CBZ;
    else if (i[31:24] == OP_BCOND) c = I_BCOND;
    else if (i[31:26] == OP_B)     c = I_B;
    return c;
  endfunction

  function automatic alu_op_t alu_op_of(input iclass_t c);
    case (c)
      I_ADDS, I_ADDI, I_LDUR, I_STUR: return ALU_ADD;
      I_SUBS:                         return ALU_SUB;
      I_LSL:                          return ALU_LSL;
      I_LSR:                          return ALU_LSR;
      default:                        return ALU_PASS_B;
    endcase
  endfunction

endpackage

// File: rtl/legv8_cond_eval.sv
// B.cond condition evaluator: full LEGv8 condition table over NZCV flags.
module legv8_cond_eval (
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_take
);
  import legv8_ctrl_pkg::*;

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_flags;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    o_take = 1'b0;
    case (i_cond)
      COND_EQ: o_take = w_z;
      COND_NE: o_take = !w_z;
      COND_HS: o_take = w_c;
      COND_LO: o_take = !w_c;
      COND_MI: o_take = w_n;
      COND_PL: o_take = !w_n;
      COND_VS: o_take = w_v;
      COND_VC: o_take = !w_v;
      COND_HI: o_take = w_c && !w_z;
      COND_LS: o_take = !(w_c && !w_z);
      COND_GE: o_take = (w_n == w_v);
      COND_LT: o_take = (w_n != w_v);
      COND_GT: o_take = !w_z && (w_n == w_v);
      COND_LE: o_take = w_z || (w_n != w_v);
      COND_AL, COND_NV: o_take = 1'b1;
      default: o_take = 1'b1;
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multicycle control FSM: fetch, decode, sequence ALU/memory/writeback.
// Optional performance counters under `LEGV8_PERF_CNT_EN.
module legv8_multicycle_ctrl #(
  parameter int FETCH_TIMEOUT = 16,
  parameter int PC_INC        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifetch_req,
  input  logic        ifetch_ack,
  input  logic [31:0] instr,
  input  logic [3:0]  flags,
  input  logic        alu_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [31:0] ir,
  output logic        imm_I,
  output logic        imm_R,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        flag_we,
  output logic        reg2loc,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        pc_we,
  output logic        pc_src,
  output logic        trap,
  output logic        busy
`ifdef LEGV8_PERF_CNT_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] stall_cycles
`endif
);
  import legv8_ctrl_pkg::*;

  localparam int CNT_W = $clog2(FETCH_TIMEOUT) + 1;

  // The PC adder is external; reject increments that break word alignment.
  if (PC_INC <= 0 || (PC_INC % 4) != 0) begin : g_pc_inc_check
    $error("PC_INC must be a positive multiple of 4");
  end

  state_t     r_state, w_next;
  iclass_t    r_class, w_class;
  alu_op_t    r_alu_op;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_ir;
  logic r_ifetch_req, r_dmem_req, r_dmem_we, r_imm_i, r_imm_r, r_alu_src;
  logic r_flag_we, r_reg2loc, r_reg_we, r_mem_to_reg, r_pc_we, r_trap, r_busy;
  logic r_b_exec, r_cbz_exec, r_bcond_exec, r_stur_mem;
  logic w_cnt_hit, w_take, w_active, w_alu_phase, w_branch;

  assign w_class     = (r_state == S_FETCH) ? decode_op(instr) : r_class;
  assign w_cnt_hit   = (r_cnt == CNT_W'(FETCH_TIMEOUT - 1));
  assign w_active    = w_next inside {S_DECODE, S_EXEC, S_MEM, S_WB};
  assign w_alu_phase = w_next inside {S_EXEC, S_MEM, S_WB};
  assign w_branch    = w_class inside {I_B, I_CBZ, I_BCOND};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:
        if (r_ifetch_req) begin
          if (ifetch_ack)     w_next = S_DECODE;
          else if (w_cnt_hit) w_next = S_TRAP;
        end
      S_DECODE: w_next = (r_class == I_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC:
        if (r_class inside {I_B, I_CBZ, I_BCOND})  w_next = S_FETCH;
        else if (r_class inside {I_LDUR, I_STUR}) w_next = S_MEM;
        else                                      w_next = S_WB;
      S_MEM:
        if (dmem_ack)       w_next = (r_class == I_STUR) ? S_FETCH : S_WB;
        else if (w_cnt_hit) w_next = S_TRAP;
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // NOTE: outputs are registered from the next state, so each one is valid
  // for exactly the cycles the FSM spends in the state that owns it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_class      <= I_ILLEGAL;
      r_cnt        <= '0;
      r_ir         <= '0;
      r_ifetch_req <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_imm_i      <= 1'b0;
      r_imm_r      <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= ALU_PASS_B;
      r_flag_we    <= 1'b0;
      r_reg2loc    <= 1'b0;
      r_reg_we     <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc_we      <= 1'b0;
      r_b_exec     <= 1'b0;
      r_cbz_exec   <= 1'b0;
      r_bcond_exec <= 1'b0;
      r_stur_mem   <= 1'b0;
      r_trap       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_class <= w_class;
      if (r_state == S_FETCH && w_next == S_DECODE) r_ir <= instr;

      if (w_next != r_state)
        r_cnt <= '0;
      else if ((r_state == S_FETCH && r_ifetch_req) || r_state == S_MEM)
        r_cnt <= r_cnt + 1'b1;

      r_ifetch_req <= (w_next == S_FETCH);
      r_imm_i      <= w_active && (w_class == I_ADDI);
      r_imm_r      <= w_active && (w_class inside {I_LSL, I_LSR});
      r_reg2loc    <= w_active && (w_class inside {I_STUR, I_CBZ});
      r_alu_src    <= w_alu_phase && (w_class inside {I_ADDI, I_LDUR, I_STUR, I_LSL, I_LSR});
      r_alu_op     <= w_alu_phase ? alu_op_of(w_class) : ALU_PASS_B;
      r_flag_we    <= (w_next == S_EXEC) && (w_class inside {I_ADDS, I_SUBS});
      r_dmem_req   <= (w_next == S_MEM);
      r_dmem_we    <= (w_next == S_MEM) && (w_class == I_STUR);
      r_stur_mem   <= (w_next == S_MEM) && (w_class == I_STUR);
      r_reg_we     <= (w_next == S_WB);
      r_mem_to_reg <= (w_next == S_WB) && (w_class == I_LDUR);
      r_pc_we      <= (w_next == S_WB) || ((w_next == S_EXEC) && w_branch);
      r_b_exec     <= (w_next == S_EXEC) && (w_class == I_B);
      r_cbz_exec   <= (w_next == S_EXEC) && (w_class == I_CBZ);
      r_bcond_exec <= (w_next == S_EXEC) && (w_class == I_BCOND);
      r_trap       <= (w_next == S_TRAP);
      r_busy       <= (w_next != S_FETCH);
    end
  end

  legv8_cond_eval u_cond_eval (
    .i_cond  (r_ir[3:0]),
    .i_flags (flags),
    .o_take  (w_take)
  );

  // Enables are gated by rst_n so a reset cycle never commits PC/register state.
  assign pc_we      = rst_n && (r_pc_we || (r_stur_mem && dmem_ack));
  assign reg_we     = rst_n && r_reg_we;
  assign flag_we    = rst_n && r_flag_we;
  assign dmem_req   = rst_n && r_dmem_req;
  assign pc_src     = r_b_exec || (r_cbz_exec && alu_zero) || (r_bcond_exec && w_take);
  assign ifetch_req = r_ifetch_req;
  assign dmem_we    = r_dmem_we;
  assign ir         = r_ir;
  assign imm_I      = r_imm_i;
  assign imm_R      = r_imm_r;
  assign alu_src    = r_alu_src;
  assign alu_op     = r_alu_op;
  assign reg2loc    = r_reg2loc;
  assign mem_to_reg = r_mem_to_reg;
  assign trap       = r_trap;
  assign busy       = r_busy;

`ifdef LEGV8_PERF_CNT_EN
  logic [31:0] r_retired, r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired      <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (pc_we) r_retired <= r_retired + 32'd1;
      if ((r_state == S_FETCH && r_ifetch_req && !ifetch_ack) ||
          (r_state == S_MEM && !dmem_ack))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign retired      = r_retired;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl: a per-cycle reference model
// queues stimulus plus expected outputs, a runner drives and compares them.
module tb_legv8_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifetch_ack = 1'b0;
  logic [31:0] instr = '0;
  logic [3:0]  flags = '0;
  logic        alu_zero = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        ifetch_req, dmem_req, dmem_we, imm_I, imm_R, alu_src, flag_we;
  logic        reg2loc, reg_we, mem_to_reg, pc_we, pc_src, trap, busy;
  logic [2:0]  alu_op;
  logic [31:0] ir;
`ifdef LEGV8_PERF_CNT_EN
  logic [31:0] retired, stall_cycles;
`endif

  always #5 clk = ~clk;

  legv8_multicycle_ctrl #(.FETCH_TIMEOUT(16), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifetch_req(ifetch_req), .ifetch_ack(ifetch_ack), .instr(instr),
    .flags(flags), .alu_zero(alu_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir(ir), .imm_I(imm_I), .imm_R(imm_R), .alu_src(alu_src), .alu_op(alu_op),
    .flag_we(flag_we), .reg2loc(reg2loc), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .pc_we(pc_we), .pc_src(pc_src), .trap(trap), .busy(busy)
`ifdef LEGV8_PERF_CNT_EN
    , .retired(retired), .stall_cycles(stall_cycles)
`endif
  );

  typedef struct packed {
    logic       ifetch_req, busy, trap, dmem_req, dmem_we, imm_i, imm_r, alu_src;
    logic [2:0] alu_op;
    logic       flag_we, reg2loc, reg_we, mem_to_reg, pc_we, pc_src;
  } outs_t;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic        zero;
    bit          fack;
    bit          mack;
    outs_t       exp;
    outs_t       mask;
    bit          chk_ir;
  } cyc_t;

  typedef enum {K_ADDS, K_SUBS, K_LSL, K_LSR, K_LDUR, K_STUR, K_ADDI,
                K_CBZ, K_BCOND, K_B, K_BAD} kind_t;

  cyc_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic kind_t classify(input logic [31:0] op);
    casez (op[31:21])
      11'b10101011000: return K_ADDS;
      11'b11101011000: return K_SUBS;
      11'b11010011011: return K_LSL;
      11'b11010011010: return K_LSR;
      11'b11111000010: return K_LDUR;
      11'b11111000000: return K_STUR;
      11'b1001000100?: return K_ADDI;
      11'b10110100???: return K_CBZ;
      11'b01010100???: return K_BCOND;
      11'b000101?????: return K_B;
      default:         return K_BAD;
    endcase
  endfunction

  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.ifetch_req = ifetch_req; o.busy = busy; o.trap = trap;
    o.dmem_req = dmem_req; o.dmem_we = dmem_we; o.imm_i = imm_I; o.imm_r = imm_R;
    o.alu_src = alu_src; o.alu_op = alu_op; o.flag_we = flag_we; o.reg2loc = reg2loc;
    o.reg_we = reg_we; o.mem_to_reg = mem_to_reg; o.pc_we = pc_we; o.pc_src = pc_src;
    return o;
  endfunction

  task automatic push(input string tag, input logic [31:0] op, input logic [3:0] fl,
                      input logic z, input bit fack, input bit mack,
                      input outs_t e, input outs_t m, input bit chk_ir);
    cyc_t c;
    c.tag = tag; c.instr = op; c.flags = fl; c.zero = z;
    c.fack = fack; c.mack = mack; c.exp = e; c.mask = m; c.chk_ir = chk_ir;
    sb.push_back(c);
  endtask

  // Reference model: expected outputs cycle by cycle for one instruction.
  task automatic push_instr(input string name, input logic [31:0] op, input int fw,
                            input int mw, input logic [3:0] fl, input logic z);
    kind_t k;
    outs_t e, m, base_m, e0;
    bit    br;
    k  = classify(op);
    br = (k == K_B) || (k == K_CBZ) || (k == K_BCOND);
    base_m = '0;
    base_m.ifetch_req = 1'b1; base_m.busy = 1'b1; base_m.trap = 1'b1;
    base_m.dmem_req = 1'b1; base_m.flag_we = 1'b1; base_m.reg_we = 1'b1; base_m.pc_we = 1'b1;

    for (int i = 0; i <= fw; i++) begin
      e = '0; e.ifetch_req = 1'b1;
      push({name, ":fetch"}, op, fl, z, (i == fw), 1'b0, e, base_m, 1'b0);
    end

    e0 = '0; e0.busy = 1'b1;
    e0.imm_i = (k == K_ADDI);
    e0.imm_r = (k == K_LSL) || (k == K_LSR);
    m = base_m; m.imm_i = 1'b1; m.imm_r = 1'b1;
    push({name, ":decode"}, op, fl, z, 1'b0, 1'b0, e0, m, 1'b1);

    if (k == K_BAD) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.busy = 1'b1; e.trap = 1'b1;
        push({name, ":trap"}, op, fl, z, 1'b0, 1'b0, e, base_m, 1'b0);
      end
      return;
    end

    e = e0; m = base_m; m.imm_i = 1'b1; m.imm_r = 1'b1;
    m.alu_src = 1'b1; m.reg2loc = 1'b1;
    m.alu_op = (k == K_B || k == K_BCOND) ? 3'b000 : 3'b111;
    e.alu_src = (k == K_ADDI) || (k == K_LDUR) || (k == K_STUR) || (k == K_LSL) || (k == K_LSR);
    case (k)
      K_ADDS, K_ADDI, K_LDUR, K_STUR: e.alu_op = 3'd1;
      K_SUBS:  e.alu_op = 3'd2;
      K_LSL:   e.alu_op = 3'd3;
      K_LSR:   e.alu_op = 3'd4;
      default: e.alu_op = 3'd0;
    endcase
    e.flag_we = (k == K_ADDS) || (k == K_SUBS);
    e.reg2loc = (k == K_STUR) || (k == K_CBZ);
    if (br) begin
      e.pc_we = 1'b1; m.pc_src = 1'b1;
      e.pc_src = (k == K_B) ? 1'b1 : (k == K_CBZ) ? z : cond_true(op[3:0], fl);
    end
    push({name, ":exec"}, op, fl, z, 1'b0, 1'b0, e, m, 1'b0);
    if (br) return;

    if (k == K_LDUR || k == K_STUR) begin
      for (int j = 0; j <= mw; j++) begin
        e = e0; e.dmem_req = 1'b1; e.dmem_we = (k == K_STUR);
        m = base_m; m.imm_i = 1'b1; m.imm_r = 1'b1; m.dmem_we = 1'b1;
        if (j == mw && k == K_STUR) begin
          e.pc_we = 1'b1; e.pc_src = 1'b0; m.pc_src = 1'b1;
        end
        push({name, ":mem"}, op, fl, z, 1'b0, (j == mw), e, m, 1'b0);
      end
      if (k == K_STUR) return;
    end

    e = e0; e.reg_we = 1'b1; e.mem_to_reg = (k == K_LDUR); e.pc_we = 1'b1; e.pc_src = 1'b0;
    m = base_m; m.imm_i = 1'b1; m.imm_r = 1'b1; m.mem_to_reg = 1'b1; m.pc_src = 1'b1;
    push({name, ":wb"}, op, fl, z, 1'b0, 1'b0, e, m, 1'b0);
  endtask

  // Entered and left at a falling edge; one queue entry per clock cycle.
  task automatic run_sb();
    cyc_t        c;
    logic [31:0] ov, ev;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      instr = c.instr; flags = c.flags; alu_zero = c.zero;
      ifetch_ack = c.fack; dmem_ack = c.mack;
      #1;
      ov = {15'b0, sample() & c.mask};
      ev = {15'b0, c.exp & c.mask};
      check(c.tag, ov, ev);
      if (c.chk_ir) check({c.tag, ":ir"}, ir, c.instr);
      @(negedge clk);
    end
    ifetch_ack = 1'b0;
    dmem_ack   = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifetch_req) break;
    end
    check(tag, {31'b0, ifetch_req}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":outs"}, {15'b0, sample()}, 32'd0);
    check({tag, ":ir"}, ir, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_idle(tag);
    rst_n = 1'b1;
    wait_req({tag, ":req"});
  endtask

  initial begin
    outs_t e, m;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    wait_req("reset:req");

    push_instr("addi",  32'h91001441, 0, 0, 4'b0000, 1'b0);
    push_instr("lsr",   32'hD3512800, 0, 0, 4'b0000, 1'b0);
    push_instr("ldur",  32'hF8400000, 0, 3, 4'b0000, 1'b0);
    push_instr("subs",  32'hEB000000, 0, 0, 4'b0000, 1'b0);
    push_instr("beq_t", 32'h54000000, 0, 0, 4'b0100, 1'b0);
    push_instr("beq_n", 32'h54000000, 0, 0, 4'b0000, 1'b0);
    push_instr("adds",  32'hAB000000, 2, 0, 4'b0000, 1'b0);
    push_instr("stur",  32'hF8000000, 0, 1, 4'b0000, 1'b0);
    push_instr("cbz_t", 32'hB4000000, 0, 0, 4'b0000, 1'b1);
    push_instr("cbz_n", 32'hB4000000, 0, 0, 4'b0000, 1'b0);
    push_instr("b",     32'h14000010, 0, 0, 4'b0000, 1'b0);
    push_instr("lsl",   32'hD3600000, 0, 0, 4'b0000, 1'b0);
    push_instr("bgt",   32'h5400000C, 0, 0, 4'b1001, 1'b0);
    push_instr("blt",   32'h5400000B, 0, 0, 4'b1000, 1'b0);
    push_instr("bhi_n", 32'h54000008, 0, 0, 4'b0110, 1'b0);
    push_instr("bal",   32'h5400000E, 0, 0, 4'b0000, 1'b0);
    push_instr("bnv",   32'h5400000F, 0, 0, 4'b0000, 1'b0);

    m = '0;
    m.ifetch_req = 1'b1; m.busy = 1'b1; m.trap = 1'b1;
    m.dmem_req = 1'b1; m.flag_we = 1'b1; m.reg_we = 1'b1; m.pc_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e = '0; e.ifetch_req = 1'b1;
      push("timeout:fetch", 32'h0, 4'b0, 1'b0, 1'b0, 1'b0, e, m, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      e = '0; e.busy = 1'b1; e.trap = 1'b1;
      push("timeout:trap", 32'h0, 4'b0, 1'b0, 1'b0, 1'b0, e, m, 1'b0);
    end
    run_sb();

    do_reset("rst_trap");
    push_instr("illegal", 32'h00000000, 0, 0, 4'b0000, 1'b0);
    run_sb();

    do_reset("rst_ill");
    push_instr("stur_rst", 32'hF8000000, 0, 5, 4'b0000, 1'b0);
    while (sb.size() > 5) void'(sb.pop_back());
    run_sb();
    rst_n = 1'b0;
    dmem_ack = 1'b1;
    #1;
    check("stur_rst:pc_we", {31'b0, pc_we}, 32'd0);
    check("stur_rst:reg_we", {31'b0, reg_we}, 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check_idle("stur_rst:after");
    rst_n = 1'b1;
    wait_req("stur_rst:req");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
